// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame constants and parity helper
package uart_pkg;
   typedef enum logic [1:0] {WL5, WL6, WL7, WL8} word_len_e;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
   localparam logic [3:0] BIT_LAST = 4'd15;
   function automatic logic [7:0] word_mask(input word_len_e wl);
      return 8'hff >> (3'd3 - 3'(wl));
   endfunction
   function automatic logic calc_parity(input logic [7:0] data, input word_len_e wl,
                                        input logic even, input logic stick);
      return stick ? ~even : (^(data & word_mask(wl))) ^ ~even;
   endfunction
endpackage

// File: rtl/settable_counter.sv
// settable_counter: down counter with synchronous load, optional wrap at zero
module settable_counter #(
   parameter int W    = 4,
   parameter bit WRAP = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         set,
   input  logic [W-1:0] load,
   input  logic         dec,
   output logic [W-1:0] count
);
   // load wins over decrement; without WRAP the count parks at zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (set) count <= load;
      else if (dec && (WRAP || count != '0)) count <= count - 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART frame serialiser (start, 5-8 data LSB first, optional parity, 1-2 stop)
module uart_tx
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic       tx,
   input  logic       div_clk_en,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   input  word_len_e  cfg_word_len,
   input  logic       cfg_parity_en,
   input  logic       cfg_even_parity,
   input  logic       cfg_force_parity,
   input  logic       cfg_two_stop,
   input  logic       cfg_break
);
   tx_state_e  state, state_nxt;
   logic [7:0] shift_reg;
   logic [3:0] bit_cnt;
   logic [2:0] data_cnt;
   logic       parity_en_q, two_stop_q, p_q, stop2_q, tx_q, tx_nxt;
   logic       accept, bit_end;

   assign tx_ready = state == IDLE;
   assign tx_busy  = state != IDLE;
   assign accept   = tx_valid & tx_ready;
   assign bit_end  = div_clk_en & tx_busy & (bit_cnt == 4'd0);
   assign tx_done  = bit_end & (state == STOP) & (~two_stop_q | stop2_q);
   assign tx       = tx_q & ~cfg_break;

   settable_counter #(.W(4), .WRAP(1'b1)) u_bit_cnt (
      .clk(clk), .rst_n(rst_n), .set(accept), .load(BIT_LAST),
      .dec(div_clk_en & tx_busy), .count(bit_cnt)
   );

   settable_counter #(.W(3), .WRAP(1'b0)) u_data_cnt (
      .clk(clk), .rst_n(rst_n), .set(accept), .load(3'd4 + 3'(cfg_word_len)),
      .dec(bit_end & (state == DATA)), .count(data_cnt)
   );

   // frame sequencing and the line level the next cycle should show
   always_comb begin
      state_nxt = state;
      tx_nxt    = state == START  ? 1'b0 :
                  state == DATA   ? shift_reg[0] :
                  state == PARITY ? p_q : 1'b1;
      case (state)
         IDLE:    if (accept) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA:    if (bit_end && data_cnt == 3'd0) state_nxt = parity_en_q ? PARITY : STOP;
         PARITY:  if (bit_end) state_nxt = STOP;
         STOP:    if (tx_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state and registered line level; reset abandons any partial frame
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         tx_q  <= 1'b1;
      end else begin
         state <= state_nxt;
         tx_q  <= tx_nxt;
      end

   // frame snapshot at accept, then shift data and track the second stop bit
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shift_reg   <= '0;
         parity_en_q <= 1'b0;
         two_stop_q  <= 1'b0;
         p_q         <= 1'b0;
         stop2_q     <= 1'b0;
      end else if (accept) begin
         shift_reg   <= tx_data;
         parity_en_q <= cfg_parity_en;
         two_stop_q  <= cfg_two_stop;
         p_q         <= calc_parity(tx_data, cfg_word_len, cfg_even_parity, cfg_force_parity);
         stop2_q     <= 1'b0;
      end else if (bit_end && state == DATA) begin
         shift_reg   <= shift_reg >> 1;
      end else if (bit_end && state == STOP) begin
         stop2_q     <= 1'b1;
      end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks plus handshake, break, freeze and reset sequences
module tb_uart_tx;
   import uart_pkg::*;

   typedef struct {
      logic [7:0]  data;
      word_len_e   wl;
      logic        par_en, even, stick, two_stop;
      logic [11:0] bits;
      int          nbits;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0, tx, div_clk_en = 1'b1, tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_done;
   logic [7:0] tx_data = 8'h00;
   word_len_e  cfg_word_len = WL8;
   logic       cfg_parity_en = 1'b0, cfg_even_parity = 1'b0, cfg_force_parity = 1'b0;
   logic       cfg_two_stop = 1'b0, cfg_break = 1'b0;
   int         n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0, prev_cyc = 0;
   vec_t       tbl[8];
   vec_t       b2b[3];

   uart_tx dut (
      .clk(clk), .rst_n(rst_n), .tx(tx), .div_clk_en(div_clk_en),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_done(tx_done), .cfg_word_len(cfg_word_len),
      .cfg_parity_en(cfg_parity_en), .cfg_even_parity(cfg_even_parity),
      .cfg_force_parity(cfg_force_parity), .cfg_two_stop(cfg_two_stop),
      .cfg_break(cfg_break)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // present a frame, wait for the accept edge, then scramble cfg to prove it was latched
   task automatic do_frame(input vec_t v, input bit keep_valid);
      int t = 0;
      @(negedge clk);
      tx_data = v.data; cfg_word_len = v.wl; cfg_parity_en = v.par_en;
      cfg_even_parity = v.even; cfg_force_parity = v.stick; cfg_two_stop = v.two_stop;
      tx_valid = 1'b1;
      while (!tx_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", tx_ready, 1);
      @(posedge clk);
      #1;
      prev_cyc = acc_cyc;
      acc_cyc  = cyc;
      if (!keep_valid) tx_valid = 1'b0;
      cfg_word_len = word_len_e'(~v.wl); cfg_parity_en = ~v.par_en;
      cfg_even_parity = ~v.even; cfg_force_parity = ~v.stick; cfg_two_stop = ~v.two_stop;
   endtask

   // sample mid-bit from accept edge + 1, then check the tx_done pulse position
   task automatic check_bits(input logic [11:0] bits, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (k == 0 ? 8 : 16) @(posedge clk);
         #1;
         chk($sformatf("bit%0d", k), tx, bits[k]);
         if (k == 0) begin
            chk("ready_low", tx_ready, 0);
            chk("busy_high", tx_busy, 1);
         end
      end
      repeat (6) @(posedge clk);
      #1 chk("done_early", tx_done, 0);
      @(posedge clk);
      #1 chk("done_pulse", tx_done, 1);
      @(posedge clk);
      #1 chk("done_clear", tx_done, 0);
      chk("ready_back", tx_ready, 1);
      chk("tx_idle", tx, 1);
   endtask

   initial begin
      tbl[0] = '{8'hA5, WL8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h34A, 10};
      tbl[1] = '{8'h83, WL7, 1'b1, 1'b1, 1'b0, 1'b0, 12'h206, 10};
      tbl[2] = '{8'h83, WL7, 1'b1, 1'b0, 1'b0, 1'b0, 12'h306, 10};
      tbl[3] = '{8'h13, WL5, 1'b1, 1'b1, 1'b1, 1'b1, 12'h1A6, 9};
      tbl[4] = '{8'h00, WL6, 1'b1, 1'b0, 1'b0, 1'b0, 12'h180, 9};
      tbl[5] = '{8'hFF, WL8, 1'b1, 1'b1, 1'b0, 1'b1, 12'hDFE, 12};
      tbl[6] = '{8'hEA, WL6, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0D4, 8};
      tbl[7] = '{8'h0A, WL5, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0D4, 8};
      b2b[0] = '{8'h3C, WL8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h278, 10};
      b2b[1] = '{8'h81, WL8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h302, 10};
      b2b[2] = '{8'h7E, WL8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h2FC, 10};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_frame(tbl[i], 1'b0);
         check_bits(tbl[i].bits, tbl[i].nbits);
      end

      for (int i = 0; i < 3; i++) begin
         do_frame(b2b[i], i < 2);
         if (i > 0) chk($sformatf("b2b_gap%0d", i), acc_cyc - prev_cyc, 161);
         check_bits(b2b[i].bits, b2b[i].nbits);
      end

      do_frame(tbl[0], 1'b0);
      repeat (56) @(posedge clk);
      #1 chk("brk_pre", tx, 1);
      cfg_break = 1'b1;
      #1 chk("brk_low", tx, 0);
      repeat (48) @(posedge clk);
      #1 chk("brk_hold", tx, 0);
      cfg_break = 1'b0;
      #1 chk("brk_release", tx, 1);
      repeat (55) @(posedge clk);
      #1 chk("brk_done", tx_done, 1);
      @(posedge clk);

      do_frame(tbl[0], 1'b0);
      repeat (8) @(posedge clk);
      #1 div_clk_en = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("frz_tx", tx, 0);
      chk("frz_busy", tx_busy, 1);
      div_clk_en = 1'b1;
      repeat (150) @(posedge clk);
      #1 chk("frz_done_early", tx_done, 0);
      @(posedge clk);
      #1 chk("frz_done", tx_done, 1);
      @(posedge clk);

      do_frame(tbl[1], 1'b0);
      repeat (136) @(posedge clk);
      #1 chk("par_bit", tx, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_ready", tx_ready, 1);
      chk("mid_rst_busy", tx_busy, 0);
      @(negedge clk) rst_n = 1'b1;
      do_frame(tbl[1], 1'b0);
      check_bits(tbl[1].bits, tbl[1].nbits);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
